register_file: RTL and testbench

32-entry general-purpose register file for the single-cycle MIPS datapath, sitting directly downstream of the write-destination mux. It consumes that mux's 5-bit write-register index plus the control unit's RegWrite and the writeback data. It provides two combinational read ports for the decode/ALU stage and a third read-only debug port. Register $0 is hardwired to zero, and writes commit on the rising clock edge.

---
 rtl/register_file.sv | 87 ++++++++
 tb/tb_register_file.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32-entry MIPS register file: two combinational read ports with optional same-cycle
// write forwarding, one unforwarded debug port, and a saturating committed-write counter.
module register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int BYPASS     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] rs,
   input  logic [ADDR_WIDTH-1:0] rt,
   output logic [DATA_WIDTH-1:0] ReadData1,
   output logic [DATA_WIDTH-1:0] ReadData2,
   input  logic                  RegWrite,
   input  logic [ADDR_WIDTH-1:0] WriteReg,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic [ADDR_WIDTH-1:0] DbgAddr,
   output logic [DATA_WIDTH-1:0] DbgData,
   output logic [15:0]           WriteCount
);

   localparam int NREG = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] rf_view [NREG];
   logic                  wr_en;
   logic [15:0]           cnt_q, cnt_d;

   // A commit needs a non-zero destination; $0 writes are dropped entirely.
   assign wr_en = RegWrite && !reset && (WriteReg != '0);

   assign rf_view[0] = '0;

   for (genvar g = 1; g < NREG; g++) begin : g_ent
      logic [DATA_WIDTH-1:0] ent_q, ent_d;

      always_comb begin
         ent_d = ent_q;
         if (wr_en && (WriteReg == ADDR_WIDTH'(g))) begin
            ent_d = WriteData;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            ent_q <= '0;
         end else begin
            ent_q <= ent_d;
         end
      end

      assign rf_view[g] = ent_q;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (wr_en && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign WriteCount = cnt_q;

   always_comb begin
      ReadData1 = rf_view[rs];
      ReadData2 = rf_view[rt];
      // wr_en already excludes index 0, so forwarding never overrides the $0 zero.
      if (BYPASS != 0) begin
         if (wr_en && (WriteReg == rs)) begin
            ReadData1 = WriteData;
         end
         if (wr_en && (WriteReg == rt)) begin
            ReadData2 = WriteData;
         end
      end
   end

   assign DbgData = rf_view[DbgAddr];

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed checks of register_file against an array-based reference model.
module tb_register_file;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs, rt, WriteReg, DbgAddr;
   logic [31:0] ReadData1, ReadData2, WriteData, DbgData;
   logic        RegWrite;
   logic [15:0] WriteCount;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic [31:0] m_regs [32];
   int          m_cnt;

   register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut (
      .clk(clk), .reset(reset), .rs(rs), .rt(rt),
      .ReadData1(ReadData1), .ReadData2(ReadData2),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
      .DbgAddr(DbgAddr), .DbgData(DbgData), .WriteCount(WriteCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference state: a plain array plus an integer counter updated per the write rules.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
         m_cnt = 0;
      end else if (RegWrite && WriteReg != 5'd0) begin
         m_regs[WriteReg] = WriteData;
         if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
   end

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (!reset && RegWrite && WriteReg == a) return WriteData;
      return m_regs[a];
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("ReadData1", ReadData1, exp_read(rs));
         check("ReadData2", ReadData2, exp_read(rt));
         check("DbgData", DbgData, (DbgAddr == 5'd0) ? 32'h0 : m_regs[DbgAddr]);
         check("WriteCount", {16'h0, WriteCount}, m_cnt[31:0]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
      rs = '0; rt = '0; DbgAddr = '0;
      tick(); tick();
      reset = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("reset_cnt", {16'h0, WriteCount}, 32'h0);

      // Reset clear
      RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEAD_BEEF;
      tick();
      RegWrite = 1'b0; DbgAddr = 5'd5;
      @(negedge clk);
      check("preload5", DbgData, 32'hDEAD_BEEF);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("clr5", DbgData, 32'h0);
      check("clr_cnt", {16'h0, WriteCount}, 32'h0);
      for (int i = 0; i < 32; i++) begin
         DbgAddr = 5'(i);
         @(negedge clk);
         check("clr_all", DbgData, 32'h0);
      end
      tick();

      // Basic write / read
      RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'h0000_1234; rs = 5'd0;
      tick();
      RegWrite = 1'b0; rs = 5'd8;
      @(negedge clk);
      check("basic_rd", ReadData1, 32'h0000_1234);
      check("basic_cnt", {16'h0, WriteCount}, 32'd1);
      tick();

      // $0 protection
      RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFF_FFFF; rs = 5'd0;
      @(negedge clk);
      check("r0_same", ReadData1, 32'h0);
      tick();
      RegWrite = 1'b0;
      @(negedge clk);
      check("r0_next", ReadData1, 32'h0);
      check("r0_cnt", {16'h0, WriteCount}, 32'd1);
      tick();

      // jal destination with dual bypass
      RegWrite = 1'b1; WriteReg = 5'd31; WriteData = 32'h0040_0008;
      rs = 5'd31; rt = 5'd31; DbgAddr = 5'd31;
      @(negedge clk);
      check("jal_byp1", ReadData1, 32'h0040_0008);
      check("jal_byp2", ReadData2, 32'h0040_0008);
      check("jal_dbg_old", DbgData, 32'h0);
      tick();
      RegWrite = 1'b0;
      @(negedge clk);
      check("jal_dbg_new", DbgData, 32'h0040_0008);
      check("jal_cnt", {16'h0, WriteCount}, 32'd2);
      tick();

      // Reset vs write collision
      RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h55;
      tick();
      reset = 1'b1; RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'd7; rs = 5'd3;
      @(negedge clk);
      check("rst_nobyp", ReadData1, 32'h55);
      tick();
      reset = 1'b0; RegWrite = 1'b0; DbgAddr = 5'd3;
      @(negedge clk);
      check("rst_r3", DbgData, 32'h0);
      check("rst_cnt", {16'h0, WriteCount}, 32'h0);
      tick();

      // Randomized traffic against the model
      for (int n = 0; n < 2000; n++) begin
         reset     = ($urandom_range(0, 63) == 0);
         RegWrite  = $urandom_range(0, 1) == 1;
         WriteReg  = 5'($urandom_range(0, 31));
         WriteData = $urandom;
         rs        = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
         rt        = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
         DbgAddr   = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
         tick();
      end

      // Counter saturation
      reset = 1'b1; RegWrite = 1'b0;
      tick();
      reset = 1'b0; RegWrite = 1'b1; WriteReg = 5'd1; rs = 5'd2; rt = 5'd1; DbgAddr = 5'd1;
      for (int n = 0; n < 65540; n++) begin
         WriteData = 32'(n);
         tick();
         if (n == 65534) check("sat_reach", {16'h0, WriteCount}, 32'h0000_FFFF);
      end
      RegWrite = 1'b0;
      @(negedge clk);
      check("sat_hold", {16'h0, WriteCount}, 32'h0000_FFFF);
      check("sat_last", DbgData, 32'h0001_0003);
      tick();

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
